// File: rtl/alu_muldiv_seq_pkg.sv
// Shared op codes, FSM state types and decode helpers for the execute unit.
package alu_muldiv_seq_pkg;

    localparam int unsigned ALU_OP_W = 6;

    // Base ALU ops
    localparam logic [ALU_OP_W-1:0] ALU_ADD    = 6'h00;
    localparam logic [ALU_OP_W-1:0] ALU_SUB    = 6'h01;
    localparam logic [ALU_OP_W-1:0] ALU_AND    = 6'h02;
    localparam logic [ALU_OP_W-1:0] ALU_OR     = 6'h03;
    localparam logic [ALU_OP_W-1:0] ALU_XOR    = 6'h04;
    localparam logic [ALU_OP_W-1:0] ALU_SLL    = 6'h05;
    localparam logic [ALU_OP_W-1:0] ALU_SRL    = 6'h06;
    localparam logic [ALU_OP_W-1:0] ALU_SRA    = 6'h07;
    localparam logic [ALU_OP_W-1:0] ALU_SLT    = 6'h08;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU   = 6'h09;
    localparam logic [ALU_OP_W-1:0] ALU_LUI    = 6'h0A;
    localparam logic [ALU_OP_W-1:0] ALU_AUIPC  = 6'h0B;
    localparam logic [ALU_OP_W-1:0] ALU_JAL    = 6'h0C;
    localparam logic [ALU_OP_W-1:0] ALU_JALR   = 6'h0D;
    localparam logic [ALU_OP_W-1:0] ALU_PASS_B = 6'h0E;
    // Branch compares
    localparam logic [ALU_OP_W-1:0] ALU_BEQ    = 6'h10;
    localparam logic [ALU_OP_W-1:0] ALU_BNE    = 6'h11;
    localparam logic [ALU_OP_W-1:0] ALU_BLT    = 6'h12;
    localparam logic [ALU_OP_W-1:0] ALU_BGE    = 6'h13;
    localparam logic [ALU_OP_W-1:0] ALU_BLTU   = 6'h14;
    localparam logic [ALU_OP_W-1:0] ALU_BGEU   = 6'h15;
    // M extension
    localparam logic [ALU_OP_W-1:0] ALU_MUL    = 6'h20;
    localparam logic [ALU_OP_W-1:0] ALU_MULH   = 6'h21;
    localparam logic [ALU_OP_W-1:0] ALU_MULHSU = 6'h22;
    localparam logic [ALU_OP_W-1:0] ALU_MULHU  = 6'h23;
    localparam logic [ALU_OP_W-1:0] ALU_DIV    = 6'h24;
    localparam logic [ALU_OP_W-1:0] ALU_DIVU   = 6'h25;
    localparam logic [ALU_OP_W-1:0] ALU_REM    = 6'h26;
    localparam logic [ALU_OP_W-1:0] ALU_REMU   = 6'h27;

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX, ST_DONE} state_t;
    typedef enum logic [1:0] {EN_IDLE, EN_CALC, EN_FIX} eng_state_t;

    function automatic logic is_mop(input logic [ALU_OP_W-1:0] op);
        return op[5:3] == 3'b100;
    endfunction

    function automatic logic is_div_op(input logic [ALU_OP_W-1:0] op);
        return is_mop(op) && op[2];
    endfunction

endpackage

// File: rtl/alu_muldiv_seq_iter_muldiv.sv
// Iterative multiply/divide engine: 1 bit per cycle on operand magnitudes,
// followed by one sign-fixup cycle in which the results are presented.
module iter_muldiv
    import alu_muldiv_seq_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            abort,
    input  logic            start,
    input  logic            a_signed,
    input  logic            b_signed,
    input  logic            is_div,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            last,
    output logic            done,
    output logic [XLEN-1:0] product_hi,
    output logic [XLEN-1:0] product_lo,
    output logic [XLEN-1:0] quot,
    output logic [XLEN-1:0] rem
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam int unsigned PW = 2 * XLEN;

    eng_state_t      state, state_nx;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] acc_hi, acc_lo, opnd;
    logic [XLEN-1:0] hi_nx, lo_nx;
    logic            neg_a, neg_b, div_q;
    logic            neg_a_in, neg_b_in;
    logic [XLEN-1:0] mag_a, mag_b, addend;
    logic [XLEN:0]   sum, shifted, trial;
    logic [PW-1:0]   prod, prod_f;

    // Operand magnitudes for the op's signedness
    always_comb begin
        neg_a_in = a_signed & a[XLEN-1];
        neg_b_in = b_signed & b[XLEN-1];
        mag_a    = neg_a_in ? (~a + XLEN'(1)) : a;
        mag_b    = neg_b_in ? (~b + XLEN'(1)) : b;
    end

    // One iteration step: shift-add multiply or restoring divide
    always_comb begin
        addend  = acc_lo[0] ? opnd : '0;
        sum     = {1'b0, acc_hi} + {1'b0, addend};
        shifted = {acc_hi, acc_lo[XLEN-1]};
        trial   = shifted - {1'b0, opnd};
        if (div_q) begin
            hi_nx = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
            lo_nx = {acc_lo[XLEN-2:0], ~trial[XLEN]};
        end else begin
            hi_nx = sum[XLEN:1];
            lo_nx = {sum[0], acc_lo[XLEN-1:1]};
        end
    end

    // Engine state register and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= EN_IDLE;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            div_q  <= 1'b0;
        end else begin
            state <= state_nx;
            if (start) begin
                cnt    <= '0;
                acc_hi <= '0;
                acc_lo <= is_div ? mag_a : mag_b;
                opnd   <= is_div ? mag_b : mag_a;
                neg_a  <= neg_a_in;
                neg_b  <= neg_b_in;
                div_q  <= is_div;
            end else if (state == EN_CALC) begin
                cnt    <= cnt + CW'(1);
                acc_hi <= hi_nx;
                acc_lo <= lo_nx;
            end
        end
    end

    // Next-state: CALC for XLEN cycles, then one FIX cycle
    always_comb begin
        state_nx = state;
        case (state)
            EN_IDLE: if (start) state_nx = EN_CALC;
            EN_CALC: if (cnt == CW'(XLEN - 1)) state_nx = EN_FIX;
            EN_FIX:  state_nx = EN_IDLE;
            default: state_nx = EN_IDLE;
        endcase
        if (abort) state_nx = EN_IDLE;
    end

    // Sign fixup of the magnitude results, presented during FIX
    always_comb begin
        last       = (state == EN_CALC) && (cnt == CW'(XLEN - 1));
        done       = (state == EN_FIX);
        prod       = {acc_hi, acc_lo};
        prod_f     = (neg_a ^ neg_b) ? (~prod + PW'(1)) : prod;
        product_hi = prod_f[PW-1:XLEN];
        product_lo = prod_f[XLEN-1:0];
        quot       = (neg_a ^ neg_b) ? (~acc_lo + XLEN'(1)) : acc_lo;
        rem        = neg_a ? (~acc_hi + XLEN'(1)) : acc_hi;
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle execute unit: single-cycle RV32I ALU/branch ops plus RV32M
// on an iterative engine, behind a valid/ready handshake.
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter bit          FAST_MUL = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALU_OP_W-1:0] op,
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     result,
    output logic                busy
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned PW  = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state, state_nx;
    logic            accept, one_cycle, start;
    logic            mop, div, b_zero, ovf, a_sgn, b_sgn;
    logic [1:0]      sel, sel_q;
    logic [XLEN-1:0] quick, eng_res;
    logic [SHW-1:0]  shamt;
    logic [PW-1:0]   ea, eb, fprod;
    logic            eng_last, eng_done;
    logic [XLEN-1:0] eng_hi, eng_lo, eng_quot, eng_rem;

    // Op decode: signedness, special cases, which result the engine returns
    always_comb begin
        mop       = is_mop(op);
        div       = is_div_op(op);
        b_zero    = (b == '0);
        ovf       = div && !op[0] && (a == MIN_INT) && (b == '1);
        a_sgn     = div ? !op[0] : (op[1:0] != 2'b11);
        b_sgn     = div ? !op[0] : !op[1];
        one_cycle = !mop || (div && (b_zero || ovf)) || (FAST_MUL && !div);
        // sel: 0 product low, 1 product high, 2 quotient, 3 remainder
        sel       = div ? {1'b1, op[1]} : {1'b0, (op[1:0] != 2'b00)};
    end

    // Single-cycle datapath, including div special cases and the fast multiplier
    always_comb begin
        shamt = b[SHW-1:0];
        ea    = {{XLEN{a_sgn & a[XLEN-1]}}, a};
        eb    = {{XLEN{b_sgn & b[XLEN-1]}}, b};
        fprod = ea * eb;
        quick = '0;
        case (op)
            ALU_ADD:    quick = a + b;
            ALU_SUB:    quick = a - b;
            ALU_AND:    quick = a & b;
            ALU_OR:     quick = a | b;
            ALU_XOR:    quick = a ^ b;
            ALU_SLL:    quick = a << shamt;
            ALU_SRL:    quick = a >> shamt;
            ALU_SRA:    quick = $signed(a) >>> shamt;
            ALU_SLT:    quick = XLEN'($signed(a) < $signed(b));
            ALU_SLTU:   quick = XLEN'(a < b);
            ALU_LUI:    quick = b;
            ALU_PASS_B: quick = b;
            ALU_AUIPC:  quick = a + b;
            ALU_JAL:    quick = a + XLEN'(4);
            ALU_JALR:   quick = a + XLEN'(4);
            ALU_BEQ:    quick = XLEN'(a == b);
            ALU_BNE:    quick = XLEN'(a != b);
            ALU_BLT:    quick = XLEN'($signed(a) < $signed(b));
            ALU_BGE:    quick = XLEN'($signed(a) >= $signed(b));
            ALU_BLTU:   quick = XLEN'(a < b);
            ALU_BGEU:   quick = XLEN'(a >= b);
            default: begin
                if (div) begin
                    if (b_zero) quick = op[1] ? a : '1;
                    else        quick = op[1] ? '0 : a;
                end else if (mop) begin
                    quick = sel[0] ? fprod[PW-1:XLEN] : fprod[XLEN-1:0];
                end
            end
        endcase
    end

    // Handshake signals and next-state; flush overrides everything but reset
    always_comb begin
        in_ready  = !flush && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
        accept    = in_valid && in_ready;
        start     = accept && !one_cycle;
        out_valid = (state == ST_DONE);
        busy      = (state != ST_IDLE);
        state_nx  = state;
        case (state)
            ST_IDLE: if (accept) state_nx = one_cycle ? ST_DONE : ST_CALC;
            ST_CALC: if (eng_last) state_nx = ST_FIX;
            ST_FIX:  if (eng_done) state_nx = ST_DONE;
            ST_DONE: begin
                if (out_ready) begin
                    if (accept) state_nx = one_cycle ? ST_DONE : ST_CALC;
                    else        state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        if (flush) state_nx = ST_IDLE;
    end

    // Engine result selection for the op captured at accept
    always_comb begin
        case (sel_q)
            2'd0:    eng_res = eng_lo;
            2'd1:    eng_res = eng_hi;
            2'd2:    eng_res = eng_quot;
            default: eng_res = eng_rem;
        endcase
    end

    // State, captured result selector and output result register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            sel_q  <= '0;
            result <= '0;
        end else begin
            state <= state_nx;
            if (accept) sel_q <= sel;
            if (accept && one_cycle) result <= quick;
            else if (state == ST_FIX) result <= eng_res;
        end
    end

    iter_muldiv #(.XLEN(XLEN)) u_iter (
        .clk        (clk),
        .rst_n      (rst_n),
        .abort      (flush),
        .start      (start),
        .a_signed   (a_sgn),
        .b_signed   (b_sgn),
        .is_div     (div),
        .a          (a),
        .b          (b),
        .last       (eng_last),
        .done       (eng_done),
        .product_hi (eng_hi),
        .product_lo (eng_lo),
        .quot       (eng_quot),
        .rem        (eng_rem)
    );

endmodule
